play_time_counter: RTL

//  Elapsed-playback timer for the current song. Sits downstream of the bluetooth

---
 rtl/play_time_counter_pkg.sv | 18 +
 rtl/play_time_counter_bcd_digit_cnt.sv | 31 +++
 rtl/play_time_counter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/play_time_counter_pkg.sv
// Shared definitions for the playback timer and the display path.
//   state_t       : timer state encoding (RUN / PAUSED / SAT)
//   SEC_TENS_MAX  : last value of the seconds-tens digit
//   DIGIT_MAX     : last value of any other decimal digit
package play_time_counter_pkg;

    // SAT is the only encoding with bit 1 set, so the saturated flag is a
    // straight flop bit rather than a decode.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PAUSED = 2'b01,
        SAT    = 2'b10
    } state_t;

    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

endpackage

// File: rtl/play_time_counter_bcd_digit_cnt.sv
// One decimal digit of the mm:ss counter, counting 0..MAX.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over inc)
//   inc      : advance by one this cycle
//   digit    : current digit value
//   carry    : inc while at MAX; drives the next digit's inc
module bcd_digit_cnt #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    localparam logic [3:0] LAST = 4'(MAX);

    assign carry = inc && (digit == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            digit <= 4'd0;
        else if (clr)
            digit <= 4'd0;
        else if (inc)
            digit <= carry ? 4'd0 : digit + 4'd1;
    end

endmodule

// File: rtl/play_time_counter.sv
// Elapsed-playback timer for the current song, output as packed BCD mm:ss.
//   clk, rst       : clock, asynchronous active-high reset
//   i_pause        : level, freezes prescaler and digits
//   i_next, i_pre,
//   i_finish_song  : rising edge restarts the timer at 00:00
//   o_dtime        : {min_tens, min_ones, sec_tens, sec_ones}
//   o_sec_tick     : one-cycle pulse, coincident with each digit increment
//   o_saturated    : high while held at MAX_MIN:59
module play_time_counter
    import play_time_counter_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int MAX_MIN = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_pause,
    input  logic        i_next,
    input  logic        i_pre,
    input  logic        i_finish_song,
    output logic [15:0] o_dtime,
    output logic        o_sec_tick,
    output logic        o_saturated
);

    localparam int          PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [15:0] SAT_VALUE  = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10),
                                          4'(SEC_TENS_MAX), 4'(DIGIT_MAX)};

    logic [2:0]      ctl, ctl_q;
    logic            restart;
    logic [PW-1:0]   presc;
    logic            advance, tick, at_max, inc, sat_hit;
    logic [3:0][3:0] digit;
    logic [4:0]      carry;
    logic            unused_carry;
    state_t          state, state_nxt;

    // Restart edge detect: several simultaneous edges still make one restart,
    // and a held-high input only fires once.
    assign ctl     = {i_finish_song, i_pre, i_next};
    assign restart = |(ctl & ~ctl_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ctl_q <= '0;
        else     ctl_q <= ctl;
    end

    // Restart outranks everything; saturation stops the prescaler so the
    // value never rolls past MAX_MIN:59.
    assign advance = !i_pause && !restart && !o_saturated;
    assign tick    = advance && (presc == PRESC_LAST);
    assign at_max  = (digit == SAT_VALUE);
    assign inc     = tick && !at_max;
    assign sat_hit = tick && at_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc <= '0;
        else if (restart)
            presc <= '0;
        else if (advance)
            presc <= tick ? '0 : presc + 1'b1;
    end

    // Strobe rises on the same edge as the digit increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_sec_tick <= 1'b0;
        else     o_sec_tick <= inc;
    end

    // Digit chain: sec_ones, sec_tens (0..5), min_ones, min_tens.
    assign carry[0] = inc;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        localparam int DMAX = (g == 1) ? SEC_TENS_MAX : DIGIT_MAX;
        bcd_digit_cnt #(.MAX(DMAX)) u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (restart),
            .inc   (carry[g]),
            .digit (digit[g]),
            .carry (carry[g+1])
        );
    end

    // The top digit can never carry: saturation holds before it would.
    assign unused_carry = carry[4];
    assign o_dtime      = digit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (restart)
            state_nxt = i_pause ? PAUSED : RUN;
        else if (sat_hit)
            state_nxt = SAT;
        else begin
            case (state)
                RUN:     state_nxt = i_pause ? PAUSED : RUN;
                PAUSED:  state_nxt = i_pause ? PAUSED : RUN;
                SAT:     state_nxt = SAT;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Output logic
    always_comb begin
        o_saturated = state[1];
    end

endmodule
